// File: rtl/cp0_op_queue.sv
// cp0_op_queue: in-order MFC0/MTC0 buffer between decode and the CP0 file.
// Pending MTC0 sources resolve by CDB snoop; issue waits for the ROB head.
module cp0_op_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RSID_WIDTH = 4,
  parameter int ROB_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_cp0_addr,
  input  logic                  in_read_flag,
  input  logic                  in_write_flag,
  input  logic                  in_write_is_rsid,
  input  logic [DATA_WIDTH-1:0] in_write_data,
  input  logic [ROB_WIDTH-1:0]  in_rob_id,
  input  logic                  cdb_valid,
  input  logic [RSID_WIDTH-1:0] cdb_rsid,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  input  logic                  commit_valid,
  input  logic [ROB_WIDTH-1:0]  commit_rob_id,
  output logic                  cp0_read_en,
  output logic [ADDR_WIDTH-1:0] cp0_read_addr,
  input  logic [DATA_WIDTH-1:0] cp0_read_data,
  output logic                  cp0_write_en,
  output logic [ADDR_WIDTH-1:0] cp0_write_addr,
  output logic [DATA_WIDTH-1:0] cp0_write_data,
  output logic                  res_valid,
  output logic [ROB_WIDTH-1:0]  res_rob_id,
  output logic [DATA_WIDTH-1:0] res_data,
  input  logic                  res_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic                  valid;
    logic                  is_write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ROB_WIDTH-1:0]  rob_id;
    logic                  waiting;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                r_q [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [PW:0]           r_count;
  logic                  r_res_valid;
  logic [ROB_WIDTH-1:0]  r_res_rob;
  logic [DATA_WIDTH-1:0] r_res_data;

  entry_t w_head;
  entry_t w_new;
  logic   w_kill;
  logic   w_acc;
  logic   w_alloc;
  logic   w_fire;

  assign w_kill   = rst | flush;
  assign in_ready = (r_count != FULL);
  assign w_acc    = in_valid & in_ready & ~w_kill;
  assign w_alloc  = w_acc & (in_read_flag | in_write_flag);
  assign w_head   = r_q[r_head];

  assign w_fire = w_head.valid & ~w_head.waiting & commit_valid &
                  (commit_rob_id == w_head.rob_id) &
                  (~r_res_valid | res_ready) & ~w_kill;

  // A source broadcast in the enqueue cycle is captured directly.
  always_comb begin
    w_new          = '0;
    w_new.valid    = 1'b1;
    w_new.is_write = in_write_flag;
    w_new.addr     = in_cp0_addr;
    w_new.rob_id   = in_rob_id;
    w_new.data     = in_write_data;
    w_new.waiting  = in_write_flag & in_write_is_rsid;
    if (w_new.waiting && cdb_valid &&
        in_write_data[RSID_WIDTH-1:0] == cdb_rsid) begin
      w_new.waiting = 1'b0;
      w_new.data    = cdb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_kill) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_q[i].valid && r_q[i].waiting && cdb_valid &&
            r_q[i].data[RSID_WIDTH-1:0] == cdb_rsid) begin
          r_q[i].data    <= cdb_data;
          r_q[i].waiting <= 1'b0;
        end
      end
      if (w_fire) begin
        r_q[r_head].valid <= 1'b0;
        r_head            <= r_head + PW'(1);
      end
      if (w_alloc) begin
        r_q[r_tail] <= w_new;
        r_tail      <= r_tail + PW'(1);
      end
      case ({w_alloc, w_fire})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    cp0_read_en    = 1'b0;
    cp0_read_addr  = '0;
    cp0_write_en   = 1'b0;
    cp0_write_addr = '0;
    cp0_write_data = '0;
    if (w_fire) begin
      if (w_head.is_write) begin
        cp0_write_en   = 1'b1;
        cp0_write_addr = w_head.addr;
        cp0_write_data = w_head.data;
      end else begin
        cp0_read_en   = 1'b1;
        cp0_read_addr = w_head.addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_res_valid <= 1'b0;
      r_res_rob   <= '0;
      r_res_data  <= '0;
    end else if (w_fire) begin
      r_res_valid <= 1'b1;
      r_res_rob   <= w_head.rob_id;
      r_res_data  <= w_head.is_write ? '0 : cp0_read_data;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid  = r_res_valid;
  assign res_rob_id = r_res_rob;
  assign res_data   = r_res_data;

endmodule

// File: tb/tb_cp0_op_queue.sv
// tb_cp0_op_queue: random + directed stimulus, queue-level reference model,
// negedge monitor checks issue order, timing, results and flush behaviour.
`timescale 1ns/1ps
module tb_cp0_op_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready;
  logic [7:0]  in_cp0_addr;
  logic        in_read_flag, in_write_flag, in_write_is_rsid;
  logic [31:0] in_write_data;
  logic [3:0]  in_rob_id;
  logic        cdb_valid;
  logic [3:0]  cdb_rsid;
  logic [31:0] cdb_data;
  logic        commit_valid;
  logic [3:0]  commit_rob_id;
  logic        cp0_read_en, cp0_write_en;
  logic [7:0]  cp0_read_addr, cp0_write_addr;
  logic [31:0] cp0_read_data, cp0_write_data;
  logic        res_valid;
  logic [3:0]  res_rob_id;
  logic [31:0] res_data;
  logic        res_ready;

  always #5 clk = ~clk;

  cp0_op_queue #(
    .DEPTH(DEPTH), .ADDR_WIDTH(8), .DATA_WIDTH(32),
    .RSID_WIDTH(4), .ROB_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cp0_addr(in_cp0_addr),
    .in_read_flag(in_read_flag), .in_write_flag(in_write_flag),
    .in_write_is_rsid(in_write_is_rsid),
    .in_write_data(in_write_data), .in_rob_id(in_rob_id),
    .cdb_valid(cdb_valid), .cdb_rsid(cdb_rsid), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
    .cp0_read_en(cp0_read_en), .cp0_read_addr(cp0_read_addr),
    .cp0_read_data(cp0_read_data),
    .cp0_write_en(cp0_write_en), .cp0_write_addr(cp0_write_addr),
    .cp0_write_data(cp0_write_data),
    .res_valid(res_valid), .res_rob_id(res_rob_id),
    .res_data(res_data), .res_ready(res_ready)
  );

  // CP0 register file model
  logic [31:0] regs [256];
  assign cp0_read_data = regs[cp0_read_addr];

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [3:0]  rob;
    logic [31:0] data;
    bit          pend;
    logic [3:0]  rsid;
    int          rdy;
  } op_t;

  typedef struct {
    logic [3:0]  rob;
    logic [31:0] data;
  } res_t;

  op_t  iq[$];
  res_t rq[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  bit   mon_en = 0;
  bit   prev_kill = 0;
  bit   drain_chk = 0;
  bit   auto_commit = 0;
  bit   auto_cdb = 0;
  logic [3:0] rob_ctr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  always @(negedge clk) begin : mon
    int   sz0;
    bit   kill, f, had_res;
    op_t  h, o;
    res_t r;
    if (!mon_en) begin
      for (int i = 0; i < 256; i++) regs[i] = 32'hC0DE_0000 | 32'(i);
      regs[8'h60] = 32'h1234;
    end else begin
      kill    = rst || flush;
      sz0     = iq.size();
      had_res = rq.size() != 0;
      chk("in_ready", 64'(in_ready), 64'(sz0 < DEPTH));
      chk("res_valid", 64'(res_valid), 64'(had_res));
      if (had_res) begin
        chk("res_rob", 64'(res_rob_id), 64'(rq[0].rob));
        chk("res_data", 64'(res_data), 64'(rq[0].data));
      end else if (prev_kill) begin
        chk("res_clear", 64'({res_rob_id, res_data}), 64'(0));
      end
      if (had_res && res_ready && !kill) void'(rq.pop_front());
      f = 0;
      if (sz0 != 0)
        f = !iq[0].pend && iq[0].rdy < cyc && commit_valid &&
            commit_rob_id == iq[0].rob && (!had_res || res_ready) && !kill;
      chk("fire", 64'(cp0_read_en | cp0_write_en), 64'(f));
      if (f) begin
        h = iq.pop_front();
        r.rob = h.rob;
        chk("strobe_kind", 64'({cp0_write_en, cp0_read_en}),
            64'(h.wr ? 2'b10 : 2'b01));
        if (h.wr) begin
          chk("wr_addr", 64'(cp0_write_addr), 64'(h.addr));
          chk("wr_data", 64'(cp0_write_data), 64'(h.data));
          r.data = '0;
          regs[h.addr] = h.data;
        end else begin
          chk("rd_addr", 64'(cp0_read_addr), 64'(h.addr));
          r.data = regs[h.addr];
        end
        rq.push_back(r);
      end else begin
        chk("idle_out", 64'({cp0_read_en, cp0_write_en, cp0_read_addr,
                             cp0_write_addr, cp0_write_data}), 64'(0));
      end
      if (kill) begin
        iq.delete();
        rq.delete();
      end else begin
        if (cdb_valid)
          foreach (iq[i])
            if (iq[i].pend && iq[i].rsid == cdb_rsid) begin
              iq[i].pend = 0;
              iq[i].data = cdb_data;
              iq[i].rdy  = cyc;
            end
        if (in_valid && sz0 < DEPTH && (in_read_flag || in_write_flag)) begin
          o.wr   = in_write_flag;
          o.addr = in_cp0_addr;
          o.rob  = in_rob_id;
          o.data = in_write_data;
          o.rsid = in_write_data[3:0];
          o.pend = in_write_flag && in_write_is_rsid;
          o.rdy  = cyc;
          if (o.pend && cdb_valid && o.rsid == cdb_rsid) begin
            o.pend = 0;
            o.data = cdb_data;
          end
          iq.push_back(o);
        end
      end
      prev_kill = kill;
      if (drain_chk)
        chk("drain_done", 64'(iq.size() == 0 && rq.size() == 0), 64'(1));
    end
  end

  task automatic tick();
    if (auto_commit) begin
      commit_valid  = 1'b1;
      commit_rob_id = (iq.size() != 0) ? iq[0].rob : 4'h0;
    end
    if (auto_cdb) begin
      cdb_valid = 1'b0;
      foreach (iq[i])
        if (iq[i].pend && !cdb_valid) begin
          cdb_valid = 1'b1;
          cdb_rsid  = iq[i].rsid;
          cdb_data  = $urandom;
        end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input bit rd, input bit wr, input bit rs,
                     input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] rob);
    in_valid         = 1'b1;
    in_read_flag     = rd;
    in_write_flag    = wr;
    in_write_is_rsid = rs;
    in_cp0_addr      = a;
    in_write_data    = d;
    in_rob_id        = rob;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic kill_case(input bit use_rst);
    res_ready   = 1'b0;
    auto_commit = 1;
    enq(1, 0, 0, 8'h40, 32'h0, 4'd4);
    enq(0, 1, 1, 8'h48, 32'h0000_0002, 4'd5);
    enq(1, 0, 0, 8'h50, 32'h0, 4'd6);
    enq(1, 0, 0, 8'h58, 32'h0, 4'd7);
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    in_valid         = 1'b1;
    in_read_flag     = 1'b0;
    in_write_flag    = 1'b1;
    in_write_is_rsid = 1'b1;
    in_write_data    = 32'h0000_0002;
    in_rob_id        = 4'd8;
    cdb_valid        = 1'b1;
    cdb_rsid         = 4'd2;
    cdb_data         = 32'h5555_5555;
    tick();
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    cdb_valid = 1'b0;
    res_ready = 1'b1;
    repeat (3) tick();
    auto_commit = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] pend_ids[$];
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_cp0_addr = '0;
    in_read_flag = 1'b0; in_write_flag = 1'b0; in_write_is_rsid = 1'b0;
    in_write_data = '0; in_rob_id = '0;
    cdb_valid = 1'b0; cdb_rsid = '0; cdb_data = '0;
    commit_valid = 1'b0; commit_rob_id = '0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 1;
    tick();
    rst = 1'b0;

    // single MFC0, latency and result
    commit_valid  = 1'b1;
    commit_rob_id = 4'd3;
    enq(1, 0, 0, 8'h60, 32'h0, 4'd3);
    repeat (3) tick();

    // MTC0 waiting on RSID 5; a non-matching broadcast first
    commit_rob_id = 4'd4;
    enq(0, 1, 1, 8'h48, 32'hABCD_0005, 4'd4);
    cdb_valid = 1'b1; cdb_rsid = 4'd4; cdb_data = 32'h1111_1111;
    tick();
    cdb_rsid = 4'd5; cdb_data = 32'hDEAD_BEEF;
    tick();
    cdb_valid = 1'b0;
    repeat (3) tick();

    // fill, overflow attempt, then wrap through 10 ops
    commit_valid = 1'b0;
    for (int k = 0; k < 4; k++)
      enq(1, 0, 0, 8'h40 + 8'(k * 8), 32'h0, 4'(10 + k));
    enq(1, 0, 0, 8'h70, 32'h0, 4'd14);
    auto_commit = 1;
    tick();
    for (int k = 0; k < 10; k++)
      enq(!k[0], k[0], 0, 8'h40 + 8'((k % 4) * 8),
          32'h1000_0000 + 32'(k), 4'(k));
    repeat (6) tick();
    auto_commit = 0;

    // in-order: younger ready entry must wait for waiting head
    commit_valid  = 1'b1;
    commit_rob_id = 4'd9;
    enq(0, 1, 1, 8'h50, 32'hFFFF_FF07, 4'd8);
    enq(1, 0, 0, 8'h50, 32'h0, 4'd9);
    repeat (3) tick();
    cdb_valid = 1'b1; cdb_rsid = 4'd7; cdb_data = 32'hCAFE_F00D;
    commit_rob_id = 4'd8;
    tick();
    cdb_valid = 1'b0;
    tick();
    commit_rob_id = 4'd9;
    repeat (3) tick();

    // result backpressure then no-bubble resume
    res_ready   = 1'b0;
    auto_commit = 1;
    enq(1, 0, 0, 8'h60, 32'h0, 4'd1);
    enq(1, 0, 0, 8'h48, 32'h0, 4'd2);
    enq(1, 0, 0, 8'h50, 32'h0, 4'd3);
    repeat (3) tick();
    res_ready = 1'b1;
    repeat (4) tick();
    auto_commit = 0;

    kill_case(1'b0);
    kill_case(1'b1);

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      int t;
      t = $urandom_range(0, 9);
      in_valid         = $urandom_range(0, 1) != 0;
      in_read_flag     = (t < 4) || (t == 8);
      in_write_flag    = (t >= 4 && t < 8) || (t == 8);
      in_write_is_rsid = $urandom_range(0, 1) != 0;
      in_cp0_addr      = 8'h40 + 8'($urandom_range(0, 3) * 8);
      in_write_data    = $urandom;
      in_rob_id        = rob_ctr;
      rob_ctr          = rob_ctr + 4'd1;
      commit_valid     = $urandom_range(0, 9) < 8;
      commit_rob_id    = (iq.size() != 0 && $urandom_range(0, 3) != 0)
                         ? iq[0].rob : 4'($urandom);
      res_ready        = $urandom_range(0, 9) < 7;
      pend_ids.delete();
      foreach (iq[i]) if (iq[i].pend) pend_ids.push_back(iq[i].rsid);
      cdb_valid = $urandom_range(0, 1) != 0;
      if (pend_ids.size() != 0 && $urandom_range(0, 9) < 6)
        cdb_rsid = pend_ids[$urandom_range(0, pend_ids.size() - 1)];
      else
        cdb_rsid = 4'($urandom);
      cdb_data = $urandom;
      flush    = $urandom_range(0, 99) < 2;
      rst      = $urandom_range(0, 199) == 0;
      tick();
    end

    // drain everything still outstanding
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0;
    res_ready = 1'b1; auto_commit = 1; auto_cdb = 1;
    for (int c = 0; c < 100; c++) begin
      if (iq.size() == 0 && rq.size() == 0) break;
      tick();
    end
    drain_chk = 1;
    tick();
    drain_chk = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
